// File: rtl/window_gen.sv
// Streaming 6x6 sliding-window generator for a raster-order 8-bit pixel stream.
// Five line buffers feed the newest column into a register window; only full windows are flagged.
module window_gen #(
   parameter int unsigned IMG_WIDTH  = 64,
   parameter int unsigned IMG_HEIGHT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pix_valid,
   input  logic                  pix_sof,
   input  logic [7:0]            pix_in,
   output logic [0:5][0:5][7:0]  window,
   output logic                  win_valid,
   output logic                  frame_done
);

   localparam int unsigned CW    = $clog2(IMG_WIDTH);
   localparam int unsigned RW    = $clog2(IMG_HEIGHT);
   localparam int unsigned LINES = 5;
   localparam int unsigned WIN   = 6;

   logic [CW-1:0] col;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] row;
   logic [RW-1:0] cur_row;
   logic          last_col;
   logic          last_row;
   logic [7:0]    lb     [0:LINES-1][0:IMG_WIDTH-1];
   logic [7:0]    column [0:WIN-1];

   // Position of the pixel being presented; a start-of-frame pixel is always (0,0).
   always_comb begin
      cur_col  = pix_sof ? '0 : col;
      cur_row  = pix_sof ? '0 : row;
      last_col = (cur_col == CW'(IMG_WIDTH - 1));
      last_row = (cur_row == RW'(IMG_HEIGHT - 1));
   end

   // Vertical column at cur_col, oldest row first, newest pixel last.
   always_comb begin
      for (int k = 0; k < WIN; k++) begin
         column[k] = '0;
      end
      for (int k = 0; k < LINES; k++) begin
         column[LINES-1-k] = lb[k][cur_col];
      end
      column[WIN-1] = pix_in;
   end

   // Line buffers hold no reset; stale contents are masked by the row/col gating.
   always_ff @(posedge clk) begin
      if (pix_valid) begin
         lb[0][cur_col] <= pix_in;
         for (int k = 1; k < LINES; k++) begin
            lb[k][cur_col] <= lb[k-1][cur_col];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col        <= '0;
         row        <= '0;
         window     <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (pix_valid) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : RW'(cur_row + RW'(1));
            end else begin
               col <= CW'(cur_col + CW'(1));
               row <= cur_row;
            end
            for (int r = 0; r < WIN; r++) begin
               for (int c = 0; c < WIN - 1; c++) begin
                  window[r][c] <= window[r][c+1];
               end
               window[r][WIN-1] <= column[r];
            end
            // Columns 0..4 still straddle the previous line, so they never qualify.
            win_valid  <= (cur_row >= RW'(LINES)) && (cur_col >= CW'(LINES));
            frame_done <= last_col && last_row;
         end
      end
   end

endmodule

// File: tb/tb_window_gen.sv
// Randomized bench for window_gen: a frame-image model predicts every window,
// valid strobe and frame_done pulse from pixel positions.
module tb_window_gen;

   localparam int W = 8;
   localparam int H = 8;

   logic                 clk;
   logic                 reset;
   logic                 pix_valid;
   logic                 pix_sof;
   logic [7:0]           pix_in;
   logic [0:5][0:5][7:0] window;
   logic                 win_valid;
   logic                 frame_done;

   window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_valid  (pix_valid),
      .pix_sof    (pix_sof),
      .pix_in     (pix_in),
      .window     (window),
      .win_valid  (win_valid),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_win    = 0;
   int n_fd     = 0;

   // Reference model state: current frame image and position of the next pixel.
   logic [7:0]           img [0:H-1][0:W-1];
   int                   m_row = 0;
   int                   m_col = 0;
   logic [0:5][0:5][7:0] exp_win = '0;
   logic                 win_known = 1'b0;

   task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic s, input logic [7:0] p);
      int   r;
      int   c;
      logic exp_valid;
      logic exp_fd;
      pix_valid = v;
      pix_sof   = s;
      pix_in    = p;
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
      if (v) begin
         if (s) begin
            m_row = 0;
            m_col = 0;
         end
         r = m_row;
         c = m_col;
         img[r][c] = p;
         exp_valid = (r >= 5) && (c >= 5);
         exp_fd    = (r == H - 1) && (c == W - 1);
         if (exp_valid) begin
            for (int i = 0; i < 6; i++)
               for (int j = 0; j < 6; j++)
                  exp_win[i][j] = img[r-5+i][c-5+j];
         end
         win_known = exp_valid;
         m_col++;
         if (m_col == W) begin
            m_col = 0;
            m_row++;
            if (m_row == H) m_row = 0;
         end
      end
      @(posedge clk);
      #1;
      check("win_valid", 288'(win_valid), 288'(exp_valid));
      check("frame_done", 288'(frame_done), 288'(exp_fd));
      if (win_known) check("window", window, exp_win);
      if (win_valid) n_win++;
      if (frame_done) n_fd++;
   endtask

   task automatic do_reset(input int cycles);
      reset     = 1'b0;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_in    = 8'h00;
      #1;
      check("rst_window", window, 288'(0));
      check("rst_win_valid", 288'(win_valid), 288'(0));
      check("rst_frame_done", 288'(frame_done), 288'(0));
      repeat (cycles) begin
         @(posedge clk);
         #1;
         pix_in = 8'($urandom);
         check("rst_hold_window", window, 288'(0));
         check("rst_hold_valid", 288'(win_valid), 288'(0));
      end
      reset     = 1'b1;
      m_row     = 0;
      m_col     = 0;
      exp_win   = '0;
      win_known = 1'b1;
   endtask

   task automatic run_frame(input int base, input int npix, input bit bubbles, input bit rnd);
      logic [7:0] val;
      for (int idx = 0; idx < npix; idx++) begin
         if (bubbles) begin
            repeat ($urandom_range(0, 2))
               step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
         end
         val = rnd ? 8'($urandom) : 8'(base + idx);
         step(1'b1, idx == 0, val);
      end
   endtask

   task automatic check_counts(input string tag, input int wins, input int fds);
      check({tag, "_win_count"}, 288'(n_win), 288'(wins));
      check({tag, "_fd_count"}, 288'(n_fd), 288'(fds));
      n_win = 0;
      n_fd  = 0;
   endtask

   initial begin
      reset     = 1'b0;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_in    = 8'h00;
      do_reset(3);
      step(1'b0, 1'b0, 8'h00);

      // Plain raster frame, value = row*8+col.
      run_frame(0, W * H, 1'b0, 1'b0);
      check_counts("plain", 9, 1);

      // Same frame with random bubbles.
      run_frame(0, W * H, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00);
      check_counts("bubbles", 9, 1);

      // Reset after pixel 30, then a full frame over stale line buffers.
      run_frame(0, 31, 1'b0, 1'b0);
      n_win = 0;
      n_fd  = 0;
      do_reset(2);
      run_frame(0, W * H, 1'b0, 1'b0);
      check_counts("mid_reset", 9, 1);

      // Frame A abandoned at pixel 20 by a new sof, then frame B.
      run_frame(0, 20, 1'b0, 1'b0);
      run_frame(0, W * H, 1'b0, 1'b0);
      check_counts("mid_sof", 9, 1);

      // Back-to-back frames, B = A + 100.
      run_frame(0, W * H, 1'b0, 1'b0);
      run_frame(100, W * H, 1'b0, 1'b0);
      check_counts("b2b", 18, 2);

      // Random pixel values with bubbles.
      run_frame(0, W * H, 1'b1, 1'b1);
      run_frame(0, W * H, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00);
      check_counts("random", 18, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
